sar_search_ctrl: RTL and testbench

Successive-approximation search controller that drives the trial operand of the team's combinational 4-bit magnitude comparator and consumes its greater/equal/less flags to recover the hidden operand. On `start` it runs an MSB-first bit-by-bit search, exits early on an equal flag, and confirms the final value with a verify compare. It reports the recovered value with `done`/`found`, and sits beside the comparator in lab datapaths.

---
 rtl/sar_search_ctrl.sv | 156 +++++++++++++++
 tb/tb_sar_search_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives `trial` into a magnitude
// comparator and recovers the hidden operand MSB-first. Optional SAR_ONEHOT_CHECK_EN.
module sar_search_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {IDLE, TEST, VERIFY, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n, acc_upd, next_bit, trial_n, result_n;
  logic [BW-1:0]    bitidx, bitidx_n, bitidx_m1;
  logic [CW-1:0]    wait_cnt, wait_n;
  logic             found_n, err_q, err_n;
  logic             sample, flag_bad;

  // Flags are only trusted on the last cycle of a compare window.
  assign sample = (wait_cnt == CW'(SETTLE));

`ifdef SAR_ONEHOT_CHECK_EN
  assign flag_bad = !(({cmp_gt, cmp_eq, cmp_lt} == 3'b100) ||
                      ({cmp_gt, cmp_eq, cmp_lt} == 3'b010) ||
                      ({cmp_gt, cmp_eq, cmp_lt} == 3'b001));
`else
  assign flag_bad = 1'b0;
`endif

  assign busy = (state == TEST) || (state == VERIFY);
  assign done = (state == DONE);
  assign err  = err_q;

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    bitidx_n  = bitidx;
    wait_n    = wait_cnt;
    trial_n   = trial;
    result_n  = result;
    found_n   = found;
    err_n     = err_q;
    bitidx_m1 = bitidx - BW'(1);
    next_bit  = '0;
    next_bit[bitidx_m1] = 1'b1;
    // No flags at all falls through to the lt behaviour (acc unchanged).
    acc_upd   = cmp_gt ? trial : acc;

    case (state)
      IDLE: begin
        if (start) begin
          state_n  = TEST;
          acc_n    = '0;
          bitidx_n = BW'(WIDTH - 1);
          wait_n   = '0;
          trial_n  = '0;
          trial_n[WIDTH-1] = 1'b1;
          result_n = '0;
          found_n  = 1'b0;
          err_n    = 1'b0;
        end
      end
      TEST: begin
        if (!sample) begin
          wait_n = wait_cnt + CW'(1);
        end else if (flag_bad) begin
          err_n    = 1'b1;
          found_n  = 1'b0;
          result_n = trial;
          wait_n   = '0;
          state_n  = DONE;
        end else if (cmp_eq) begin
          result_n = trial;
          found_n  = 1'b1;
          wait_n   = '0;
          state_n  = DONE;
        end else begin
          acc_n  = acc_upd;
          wait_n = '0;
          if (bitidx != '0) begin
            bitidx_n = bitidx_m1;
            trial_n  = acc_upd | next_bit;
          end else begin
            trial_n = acc_upd;
            state_n = VERIFY;
          end
        end
      end
      VERIFY: begin
        if (!sample) begin
          wait_n = wait_cnt + CW'(1);
        end else begin
          wait_n  = '0;
          state_n = DONE;
          if (flag_bad) begin
            err_n    = 1'b1;
            found_n  = 1'b0;
            result_n = trial;
          end else begin
            result_n = acc;
            found_n  = cmp_eq;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      bitidx   <= '0;
      wait_cnt <= '0;
      trial    <= '0;
      result   <= '0;
      found    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      acc      <= acc_n;
      bitidx   <= bitidx_n;
      wait_cnt <= wait_n;
      trial    <= trial_n;
      result   <= result_n;
      found    <= found_n;
      err_q    <= err_n;
    end
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl: two instances (SETTLE=0 and SETTLE=2),
// each with a behavioural comparator model and a trial-sequence scoreboard.
module tb_sar_search_ctrl;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start0, start1, force0, force1;
  logic [W-1:0] tgt0, tgt1;
  logic         gt0, eq0, lt0, gt1, eq1, lt1;
  logic [W-1:0] trial0, trial1, result0, result1;
  logic         busy0, busy1, done0, done1, found0, found1, err0, err1;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] rs_seq[3];
  int           tests_run = 0;
  int           tests_failed = 0;
  int           sel = 0;

  logic [W-1:0] o_trial, o_result;
  logic         o_busy, o_done, o_found, o_err;

  sar_search_ctrl #(.WIDTH(W), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .cmp_gt(gt0), .cmp_eq(eq0), .cmp_lt(lt0),
    .trial(trial0), .busy(busy0), .done(done0),
    .result(result0), .found(found0), .err(err0)
  );

  sar_search_ctrl #(.WIDTH(W), .SETTLE(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .cmp_gt(gt1), .cmp_eq(eq1), .cmp_lt(lt1),
    .trial(trial1), .busy(busy1), .done(done1),
    .result(result1), .found(found1), .err(err1)
  );

  // Comparator models; force drives the illegal gt+lt combination.
  always_comb begin
    gt0 = (tgt0 > trial0);
    eq0 = (tgt0 == trial0);
    lt0 = (tgt0 < trial0);
    if (force0) begin
      gt0 = 1'b1; eq0 = 1'b0; lt0 = 1'b1;
    end
    gt1 = (tgt1 > trial1);
    eq1 = (tgt1 == trial1);
    lt1 = (tgt1 < trial1);
    if (force1) begin
      gt1 = 1'b1; eq1 = 1'b0; lt1 = 1'b1;
    end
  end

  always_comb begin
    o_trial  = (sel == 0) ? trial0  : trial1;
    o_result = (sel == 0) ? result0 : result1;
    o_busy   = (sel == 0) ? busy0   : busy1;
    o_done   = (sel == 0) ? done0   : done1;
    o_found  = (sel == 0) ? found0  : found1;
    o_err    = (sel == 0) ? err0    : err1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start0 = v; else start1 = v;
  endtask

  task automatic set_force(input logic v);
    if (sel == 0) force0 = v; else force1 = v;
  endtask

  // Expected trials from the bit-position formula: bits of the target above
  // position p, with bit p set; stop on a match, else finish with a verify at 0.
  function automatic void push_model_seq(input logic [W-1:0] t);
    logic [W-1:0] tr;
    for (int p = W - 1; p >= 0; p--) begin
      tr = (t >> (p + 1)) << (p + 1);
      tr[p] = 1'b1;
      exp_q.push_back(tr);
      if (tr == t) return;
    end
    exp_q.push_back('0);
  endfunction

  task automatic run_search(input string tag, input int settle, input int exp_lat,
                            input logic [W-1:0] exp_res, input logic exp_found,
                            input logic exp_err, input int hold, input int pulse_at,
                            input int force_at);
    int  k;
    bit  seen;
    k = 0;
    seen = 0;
    @(negedge clk);
    set_start(1'b1);
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      if (k == 1 && hold == 0) set_start(1'b0);
      if (pulse_at > 0 && k == pulse_at) set_start(1'b1);
      if (pulse_at > 0 && k == pulse_at + 1) set_start(1'b0);
      set_force(k == force_at);
      if (o_done) begin
        seen = 1;
        check({tag, "_latency"}, k, exp_lat);
        check({tag, "_result"}, o_result, exp_res);
        check({tag, "_found"}, o_found, exp_found);
        check({tag, "_err"}, o_err, exp_err);
        check({tag, "_busy_in_done"}, o_busy, 0);
      end else begin
        check({tag, "_busy"}, o_busy, 1);
        if (exp_q.size() > 0) begin
          check({tag, "_trial"}, o_trial, exp_q[0]);
          if (k % (settle + 1) == 0) void'(exp_q.pop_front());
        end else begin
          check({tag, "_q_underrun"}, exp_q.size(), 1);
        end
      end
    end
    set_force(1'b0);
    if (!seen) check({tag, "_timeout"}, k, exp_lat);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_done(input string tag, input logic [W-1:0] exp_res);
    bit seen;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (o_done) begin
        seen = 1;
        check({tag, "_result"}, o_result, exp_res);
      end
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_trial"}, o_trial, 0);
    check({tag, "_result"}, o_result, 0);
    check({tag, "_found"}, o_found, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
  endtask

  initial begin
    logic [W-1:0] t;
    int           n;
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    force0 = 1'b0; force1 = 1'b0;
    tgt0 = '0; tgt1 = '0;
    rs_seq[0] = 4'd8; rs_seq[1] = 4'd12; rs_seq[2] = 4'd10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 0; #0 check_all_zero("reset0");
    sel = 1; #0 check_all_zero("reset1");
    rst = 1'b0;

    // Target 5, SETTLE=0: 8,4,6,5 then done in cycle 5.
    sel = 0; tgt0 = 4'd5;
    exp_q.push_back(4'd8); exp_q.push_back(4'd4);
    exp_q.push_back(4'd6); exp_q.push_back(4'd5);
    run_search("t5", 0, 5, 4'd5, 1'b1, 1'b0, 0, 0, 0);

    // Target 0 goes through VERIFY.
    tgt0 = 4'd0;
    exp_q.push_back(4'd8); exp_q.push_back(4'd4); exp_q.push_back(4'd2);
    exp_q.push_back(4'd1); exp_q.push_back(4'd0);
    run_search("t0", 0, 6, 4'd0, 1'b1, 1'b0, 0, 0, 0);

    // Target 15 with SETTLE=2: each trial held three cycles.
    sel = 1; tgt1 = 4'd15;
    exp_q.push_back(4'd8); exp_q.push_back(4'd12);
    exp_q.push_back(4'd14); exp_q.push_back(4'd15);
    run_search("t15s2", 2, 13, 4'd15, 1'b1, 1'b0, 0, 0, 0);

    // MSB-only target exits on the first compare.
    sel = 0; tgt0 = 4'd8;
    exp_q.push_back(4'd8);
    run_search("t8", 0, 2, 4'd8, 1'b1, 1'b0, 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      sel = 0; t = 4'($urandom_range(0, 15)); tgt0 = t;
      push_model_seq(t); n = exp_q.size();
      run_search("rand0", 0, n + 1, t, 1'b1, 1'b0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      sel = 1; t = 4'($urandom_range(0, 15)); tgt1 = t;
      push_model_seq(t); n = exp_q.size();
      run_search("rand1", 2, n * 3 + 1, t, 1'b1, 1'b0, 0, 0, 0);
    end

    // Start held high: DONE ignores it, IDLE then accepts it.
    sel = 0; tgt0 = 4'd6;
    exp_q.push_back(4'd8); exp_q.push_back(4'd4); exp_q.push_back(4'd6);
    run_search("hold", 0, 4, 4'd6, 1'b1, 1'b0, 1, 0, 0);
    @(negedge clk);
    check("hold_idle_busy", o_busy, 0);
    check("hold_idle_done", o_done, 0);
    check("hold_idle_result", o_result, 6);
    @(negedge clk);
    check("hold_restart_busy", o_busy, 1);
    check("hold_restart_trial", o_trial, 8);
    check("hold_restart_result_clr", o_result, 0);
    set_start(1'b0);
    wait_done("hold_second", 4'd6);

    // Second start pulse mid-search has no effect.
    tgt0 = 4'd11;
    push_model_seq(4'd11);
    run_search("pulse", 0, 5, 4'd11, 1'b1, 1'b0, 0, 2, 0);

    // Reset during the third compare of a target-9 search.
    tgt0 = 4'd9;
    @(negedge clk);
    start0 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) start0 = 1'b0;
      check("rst_pre_trial", o_trial, rs_seq[k-1]);
      check("rst_pre_busy", o_busy, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    check("rst_stay_idle", o_busy, 0);
    exp_q.push_back(4'd8); exp_q.push_back(4'd12);
    exp_q.push_back(4'd10); exp_q.push_back(4'd9);
    run_search("after_rst", 0, 5, 4'd9, 1'b1, 1'b0, 0, 0, 0);

    // gt and lt both high on the second compare, target 3.
    tgt0 = 4'd3;
`ifdef SAR_ONEHOT_CHECK_EN
    exp_q.push_back(4'd8); exp_q.push_back(4'd4);
    run_search("onehot", 0, 3, 4'd4, 1'b0, 1'b1, 0, 0, 2);
`else
    exp_q.push_back(4'd8); exp_q.push_back(4'd4); exp_q.push_back(4'd6);
    exp_q.push_back(4'd5); exp_q.push_back(4'd4);
    run_search("onehot", 0, 6, 4'd4, 1'b0, 1'b0, 0, 0, 2);
`endif

    // A clean search afterwards clears err and found state.
    tgt0 = 4'd7;
    push_model_seq(4'd7);
    run_search("clean", 0, 5, 4'd7, 1'b1, 1'b0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
